// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM among three requesters.
//   Port 0 = CPU instruction fetch (read only)
//   Port 1 = CPU load/store data (read/write)
//   Port 2 = video scan-out reader (read only)
// Priority: an aged video request first, then data, then fetch, then video.
// Grants are combinational; read-valid strobes are registered to match the
// RAM's one-cycle read latency.
//
// Ports:
//   clock, reset                    clock and async active-high reset
//   fetch_req/addr -> fetch_gnt     fetch request / grant
//   fetch_rvalid                    fetch read data valid on rdata
//   data_req/we/addr/wdata          load/store request
//   data_gnt, data_rvalid           data grant / load data valid
//   video_req/addr -> video_gnt     video request / grant
//   video_rvalid                    video read data valid
//   rdata                           shared read return (ram_rdata passthrough)
//   ram_addr/wdata/we, ram_rdata    RAM macro interface
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,

  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,

  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  output logic              video_gnt,
  output logic              video_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  // A zero MAX_WAIT still needs a 1-bit counter to keep the code uniform.
  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] video_wait;
  logic              video_urgent;

  // Video preempts once it has been held off MAX_WAIT cycles.
  generate
    if (MAX_WAIT == 0) begin : g_video_always_urgent
      always_comb video_urgent = video_req;
    end else begin : g_video_aged
      always_comb video_urgent = video_req && (video_wait >= WAIT_MAX);
    end
  endgenerate

  // Grant selection and RAM address mux; nothing is granted during reset.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    video_gnt = 1'b0;
    ram_addr  = '0;
    if (!reset) begin
      if (video_urgent) begin
        video_gnt = 1'b1;
        ram_addr  = video_addr;
      end else if (data_req) begin
        data_gnt = 1'b1;
        ram_addr = data_addr;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
        ram_addr  = fetch_addr;
      end else if (video_req) begin
        video_gnt = 1'b1;
        ram_addr  = video_addr;
      end
    end
  end

  always_comb begin
    ram_wdata = data_wdata;
    ram_we    = data_gnt & data_we;
    rdata     = ram_rdata;
  end

  // Video aging counter: counts denied cycles, saturating at MAX_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      video_wait <= '0;
    end else if (!video_req || video_gnt) begin
      video_wait <= '0;
    end else if (video_wait != WAIT_MAX) begin
      video_wait <= video_wait + WAIT_W'(1);
    end
  end

  // Read-valid strobes line up with the RAM's one-cycle read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      video_rvalid <= 1'b0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      data_rvalid  <= data_gnt & ~data_we;
      video_rvalid <= video_gnt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Instance u_dut uses MAX_WAIT=4
// with a behavioural RAM; instance u_dut0 uses MAX_WAIT=0 on the same inputs.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req, data_req, data_we, video_req;
  logic [15:0] fetch_addr, data_addr, data_wdata, video_addr;
  logic        fetch_gnt, data_gnt, video_gnt;
  logic        fetch_rvalid, data_rvalid, video_rvalid;
  logic [15:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;

  logic        fetch_gnt0, data_gnt0, video_gnt0;
  logic        fetch_rvalid0, data_rvalid0, video_rvalid0;
  logic [15:0] rdata0, ram_addr0, ram_wdata0;
  logic        ram_we0;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) u_dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .video_req(video_req), .video_addr(video_addr),
    .video_gnt(video_gnt), .video_rvalid(video_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt0), .fetch_rvalid(fetch_rvalid0),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt0), .data_rvalid(data_rvalid0),
    .video_req(video_req), .video_addr(video_addr),
    .video_gnt(video_gnt0), .video_rvalid(video_rvalid0),
    .rdata(rdata0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_we(ram_we0), .ram_rdata(16'h0000)
  );

  // Behavioural single-port synchronous RAM, one-cycle read latency.
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive at negedge, then let combinational outputs settle.
  task automatic at_negedge();
    @(negedge clock);
  endtask

  task automatic after_posedge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0; data_req = 1'b0; data_we = 1'b0; video_req = 1'b0;
    fetch_addr = 16'h0; data_addr = 16'h0; data_wdata = 16'h0; video_addr = 16'h0;
  endtask

  initial begin
    idle_inputs();
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0300] = 16'h5A5A;
    reset = 1'b1;
    #1;
    check("rst_gnt", {fetch_gnt, data_gnt, video_gnt}, 3'b000);
    check("rst_rvalid", {fetch_rvalid, data_rvalid, video_rvalid}, 3'b000);
    check("rst_ram", {ram_we, ram_addr}, 17'h0);
    repeat (2) @(posedge clock);
    at_negedge();
    reset = 1'b0;

    // Uncontended fetch read.
    at_negedge();
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    #1;
    check("fetch_gnt", {fetch_gnt, data_gnt, video_gnt}, 3'b100);
    check("fetch_ram_addr", ram_addr, 16'h0010);
    check("fetch_ram_we", ram_we, 1'b0);
    after_posedge();
    check("fetch_rvalid", {fetch_rvalid, data_rvalid, video_rvalid}, 3'b100);
    check("fetch_rdata", rdata, 16'hA5A5);
    at_negedge();
    fetch_req = 1'b0;
    #1;
    check("idle_ram_addr", ram_addr, 16'h0000);
    after_posedge();
    check("fetch_rvalid_drop", fetch_rvalid, 1'b0);

    // Store then load back the same word.
    at_negedge();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h1234;
    #1;
    check("store_gnt", {fetch_gnt, data_gnt, video_gnt}, 3'b010);
    check("store_ram", {ram_we, ram_addr, ram_wdata}, {1'b1, 16'h0200, 16'h1234});
    after_posedge();
    check("store_no_rvalid", data_rvalid, 1'b0);
    at_negedge();
    data_we = 1'b0;
    #1;
    check("load_gnt", {data_gnt, ram_we}, 2'b10);
    after_posedge();
    check("load_rvalid", {fetch_rvalid, data_rvalid, video_rvalid}, 3'b010);
    check("load_rdata", rdata, 16'h1234);
    at_negedge();
    data_req = 1'b0;
    after_posedge();

    // All three requesting with no video aging: data wins.
    at_negedge();
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    data_req = 1'b1; data_addr = 16'h0200;
    video_req = 1'b1; video_addr = 16'h0300;
    #1;
    check("all3_gnt", {fetch_gnt, data_gnt, video_gnt}, 3'b010);
    check("all3_ram_addr", ram_addr, 16'h0200);
    check("all3_gnt_mw0", {fetch_gnt0, data_gnt0, video_gnt0}, 3'b001);
    check("all3_ram_addr_mw0", ram_addr0, 16'h0300);
    at_negedge();
    idle_inputs();
    after_posedge();   // video_req low clears the aging counter

    // Data and video continuous: video every 5th cycle with MAX_WAIT=4,
    // every cycle with MAX_WAIT=0.
    at_negedge();
    data_req = 1'b1; data_addr = 16'h0200;
    video_req = 1'b1; video_addr = 16'h0300;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("age_gnt_c%0d", i), {data_gnt, video_gnt},
            (i % 5 == 4) ? 2'b01 : 2'b10);
      check($sformatf("age_addr_c%0d", i), ram_addr,
            (i % 5 == 4) ? 16'h0300 : 16'h0200);
      check($sformatf("mw0_gnt_c%0d", i), {data_gnt0, video_gnt0}, 2'b01);
      after_posedge();
      check($sformatf("age_rvalid_c%0d", i), {data_rvalid, video_rvalid},
            (i % 5 == 4) ? 2'b01 : 2'b10);
      if (i % 5 == 4) check($sformatf("video_rdata_c%0d", i), rdata, 16'h5A5A);
      at_negedge();
    end
    idle_inputs();
    after_posedge();

    // Load granted, then reset lands before the next edge and holds 2 cycles.
    at_negedge();
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0200;
    #1;
    check("rstmid_gnt", data_gnt, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_gnt_off", {fetch_gnt, data_gnt, video_gnt}, 3'b000);
    check("rstmid_ram", {ram_we, ram_addr}, 17'h0);
    for (int i = 0; i < 2; i++) begin
      after_posedge();
      check($sformatf("rstmid_rvalid_c%0d", i),
            {fetch_rvalid, data_rvalid, video_rvalid}, 3'b000);
      check($sformatf("rstmid_gnt_c%0d", i), {data_gnt, ram_we, ram_addr}, 18'h0);
    end
    at_negedge();
    reset = 1'b0;
    data_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      after_posedge();
      check($sformatf("post_rst_rvalid_c%0d", i), data_rvalid, 1'b0);
    end

    // Normal operation after release.
    at_negedge();
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    #1;
    check("post_rst_fetch_gnt", fetch_gnt, 1'b1);
    after_posedge();
    check("post_rst_fetch_rdata", {fetch_rvalid, rdata}, {1'b1, 16'hA5A5});
    at_negedge();
    idle_inputs();
    after_posedge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
